// File: rtl/serdes_tx_sched.sv
// Transmit symbol scheduler: frames requester bytes into SYMBOL_BITS-clock symbols with comma preamble/idle/forced-comma insertion.
// Latency: an accepted byte is loaded one clock after the handshake; o_Ready is only offered on symbol boundaries.
module serdes_tx_sched #(
  parameter int         SYMBOL_BITS  = 10,
  parameter int         PREAMBLE_LEN = 4,
  parameter int         MAX_BURST    = 16,
  parameter logic [7:0] COMMA        = 8'hBC
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_En,
  input  logic [7:0]  i_Data,
  input  logic        i_Valid,
  output logic        o_Ready,
  output logic        o_Load,
  output logic [7:0]  o_Sym_Data,
  output logic        o_K,
  output logic [3:0]  o_Bit_Idx,
  output logic        o_Aligned,
  output logic [15:0] o_Sym_Count
);

  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [3:0]    LAST_IDX  = 4'(SYMBOL_BITS - 1);
  localparam logic [PW-1:0] PRE_LEN   = PW'(PREAMBLE_LEN);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_load, w_load_nxt;
  logic [7:0]    r_sym, w_sym_nxt;
  logic          r_k, w_k_nxt;
  logic [3:0]    r_bit_idx, w_bit_nxt;
  logic          r_aligned, w_aligned_nxt;
  logic [15:0]   r_cnt, w_cnt_nxt;
  logic [BW-1:0] r_burst, w_burst_nxt;
  logic [PW-1:0] r_pre_cnt, w_pre_nxt;
  logic          w_boundary;
  logic          w_ready;
  logic          w_data_slot;

  assign w_boundary = (r_bit_idx == LAST_IDX);
  assign w_ready    = ~i_Rst & w_boundary & i_En & (r_burst < BURST_MAX) &
                      ((r_state == DATA) | ((r_state == PREAMBLE) & (r_pre_cnt == PRE_LEN)));

  always_comb begin
    w_state_nxt   = r_state;
    w_load_nxt    = 1'b0;
    w_sym_nxt     = r_sym;
    w_k_nxt       = r_k;
    w_bit_nxt     = w_boundary ? 4'd0 : r_bit_idx + 4'd1;
    w_aligned_nxt = r_aligned;
    w_burst_nxt   = r_burst;
    w_pre_nxt     = r_pre_cnt;
    w_cnt_nxt     = r_cnt;
    w_data_slot   = 1'b0;
    case (r_state)
      IDLE: begin
        w_bit_nxt = LAST_IDX;
        if (i_En) begin
          w_state_nxt = PREAMBLE;
          w_load_nxt  = 1'b1;
          w_sym_nxt   = COMMA;
          w_k_nxt     = 1'b1;
          w_bit_nxt   = 4'd0;
          w_pre_nxt   = PW'(1);
        end
      end
      PREAMBLE: begin
        if (w_boundary) begin
          if (!i_En) begin
            w_state_nxt = IDLE;
            w_pre_nxt   = '0;
            w_bit_nxt   = LAST_IDX;
          end else if (r_pre_cnt < PRE_LEN) begin
            w_load_nxt = 1'b1;
            w_sym_nxt  = COMMA;
            w_k_nxt    = 1'b1;
            w_pre_nxt  = r_pre_cnt + PW'(1);
          end else begin
            // The first data-phase symbol goes out on the same edge as alignment.
            w_state_nxt   = DATA;
            w_aligned_nxt = 1'b1;
            w_data_slot   = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_boundary) begin
          if (!i_En) begin
            w_state_nxt   = IDLE;
            w_aligned_nxt = 1'b0;
            w_burst_nxt   = '0;
            w_pre_nxt     = '0;
            w_bit_nxt     = LAST_IDX;
          end else begin
            w_data_slot = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_data_slot) begin
      w_load_nxt = 1'b1;
      if (r_burst == BURST_MAX) begin
        w_sym_nxt   = COMMA;
        w_k_nxt     = 1'b1;
        w_burst_nxt = '0;
      end else if (i_Valid && w_ready) begin
        w_sym_nxt   = i_Data;
        w_k_nxt     = 1'b0;
        w_burst_nxt = r_burst + BW'(1);
        w_cnt_nxt   = r_cnt + 16'd1;
      end else begin
        w_sym_nxt   = COMMA;
        w_k_nxt     = 1'b1;
        w_burst_nxt = '0;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state   <= IDLE;
      r_load    <= 1'b0;
      r_sym     <= 8'd0;
      r_k       <= 1'b0;
      r_bit_idx <= LAST_IDX;
      r_aligned <= 1'b0;
      r_cnt     <= 16'd0;
      r_burst   <= '0;
      r_pre_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_load    <= w_load_nxt;
      r_sym     <= w_sym_nxt;
      r_k       <= w_k_nxt;
      r_bit_idx <= w_bit_nxt;
      r_aligned <= w_aligned_nxt;
      r_cnt     <= w_cnt_nxt;
      r_burst   <= w_burst_nxt;
      r_pre_cnt <= w_pre_nxt;
    end
  end

  assign o_Ready     = w_ready;
  assign o_Load      = r_load;
  assign o_Sym_Data  = r_sym;
  assign o_K         = r_k;
  assign o_Bit_Idx   = r_bit_idx;
  assign o_Aligned   = r_aligned;
  assign o_Sym_Count = r_cnt;

endmodule
